// File: rtl/mem_comp_pkg.sv
// mem_comp_pkg: shared types and default widths for the MEM->Complete arbiter.
//   ld_result_t : load result record {data, pc, tag} at the default widths
//   src_e       : grant source encoding (SRC_LSQ doubles as cmp_from_lsq=1)
package mem_comp_pkg;

    localparam int XLEN_D  = 32;
    localparam int TAG_W_D = 6;
    localparam int DEPTH_D = 2;
    localparam int CNT_W_D = 16;

    typedef enum logic {
        SRC_MEM = 1'b0,
        SRC_LSQ = 1'b1
    } src_e;

    typedef struct packed {
        logic [XLEN_D-1:0]  data;
        logic [XLEN_D-1:0]  pc;
        logic [TAG_W_D-1:0] tag;
    } ld_result_t;

endpackage

// File: rtl/ld_result_fifo.sv
// ld_result_fifo: small synchronous FIFO holding load results for one source.
//   clk, rst     : clock, synchronous active-high reset
//   flush        : drop all held entries
//   push, din    : write an entry (ignored when full)
//   pop          : retire the head (ignored when empty)
//   full, empty  : status from registered occupancy
//   head         : oldest entry, valid when !empty
module ld_result_fifo #(
    parameter int W     = 70,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  store [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = store[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers are exactly log2(DEPTH) bits, so they wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= din;
    end

endmodule

// File: rtl/mem_comp_arbiter.sv
// mem_comp_arbiter: merges LSQ-forwarded and data-memory load results onto the
// single MEM->Complete register with round-robin arbitration.
//   clk, rst, flush                     : clock, sync active-high reset, pipeline flush
//   lsq_valid/ready/data/pc/tag         : LSQ forwarded-load input handshake
//   mem_valid/ready/data/pc/tag         : data-memory return input handshake
//   cmp_valid/ready/data/pc/tag         : registered result toward completion
//   cmp_from_lsq                        : 1 = result came from LSQ
//   conflict_cnt                        : saturating count of cycles both heads valid
module mem_comp_arbiter
    import mem_comp_pkg::*;
#(
    parameter int XLEN  = XLEN_D,
    parameter int TAG_W = TAG_W_D,
    parameter int DEPTH = DEPTH_D,
    parameter int CNT_W = CNT_W_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             lsq_valid,
    output logic             lsq_ready,
    input  logic [XLEN-1:0]  lsq_data,
    input  logic [XLEN-1:0]  lsq_pc,
    input  logic [TAG_W-1:0] lsq_tag,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [XLEN-1:0]  mem_data,
    input  logic [XLEN-1:0]  mem_pc,
    input  logic [TAG_W-1:0] mem_tag,
    output logic             cmp_valid,
    input  logic             cmp_ready,
    output logic [XLEN-1:0]  cmp_data,
    output logic [XLEN-1:0]  cmp_pc,
    output logic [TAG_W-1:0] cmp_tag,
    output logic             cmp_from_lsq,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam int RW = 2*XLEN + TAG_W;

    logic          lsq_full, lsq_empty, mem_full, mem_empty;
    logic [RW-1:0] lsq_head, mem_head, gnt_head;
    logic          lsq_pop, mem_pop;
    logic          both, load, gnt_lsq;
    src_e          rr;

    // Ready depends only on registered occupancy, never on valid/cmp_ready.
    assign lsq_ready = !lsq_full;
    assign mem_ready = !mem_full;

    ld_result_fifo #(.W(RW), .DEPTH(DEPTH)) u_lsq_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (lsq_valid && lsq_ready),
        .din   ({lsq_data, lsq_pc, lsq_tag}),
        .pop   (lsq_pop),
        .full  (lsq_full),
        .empty (lsq_empty),
        .head  (lsq_head)
    );

    ld_result_fifo #(.W(RW), .DEPTH(DEPTH)) u_mem_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (mem_valid && mem_ready),
        .din   ({mem_data, mem_pc, mem_tag}),
        .pop   (mem_pop),
        .full  (mem_full),
        .empty (mem_empty),
        .head  (mem_head)
    );

    always_comb begin
        both     = !lsq_empty && !mem_empty;
        load     = (!cmp_valid || cmp_ready) && (!lsq_empty || !mem_empty);
        gnt_lsq  = both ? (rr == SRC_LSQ) : !lsq_empty;
        lsq_pop  = load && gnt_lsq;
        mem_pop  = load && !gnt_lsq;
        gnt_head = gnt_lsq ? lsq_head : mem_head;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_valid    <= 1'b0;
            cmp_data     <= '0;
            cmp_pc       <= '0;
            cmp_tag      <= '0;
            cmp_from_lsq <= 1'b0;
            conflict_cnt <= '0;
            rr           <= SRC_LSQ;
        end else begin
            // Counted regardless of flush; statistics survive a flush.
            if (both && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 1'b1;

            if (flush) begin
                cmp_valid <= 1'b0;
                rr        <= SRC_LSQ;
            end else if (load) begin
                cmp_valid                  <= 1'b1;
                {cmp_data, cmp_pc, cmp_tag} <= gnt_head;
                cmp_from_lsq               <= gnt_lsq;
                // Any grant hands priority to the other source.
                rr                         <= gnt_lsq ? SRC_MEM : SRC_LSQ;
            end else if (cmp_ready) begin
                cmp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_comp_arbiter.sv
// tb_mem_comp_arbiter: directed + randomized bench with a queue-based reference model.
module tb_mem_comp_arbiter;
    import mem_comp_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        lsq_valid, lsq_ready, mem_valid, mem_ready;
    logic [31:0] lsq_data, lsq_pc, mem_data, mem_pc;
    logic [5:0]  lsq_tag, mem_tag;
    logic        cmp_valid, cmp_ready, cmp_from_lsq;
    logic [31:0] cmp_data, cmp_pc;
    logic [5:0]  cmp_tag;
    logic [15:0] conflict_cnt;

    always #5 clk = ~clk;

    mem_comp_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .lsq_valid(lsq_valid), .lsq_ready(lsq_ready), .lsq_data(lsq_data),
        .lsq_pc(lsq_pc), .lsq_tag(lsq_tag),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data),
        .mem_pc(mem_pc), .mem_tag(mem_tag),
        .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_data(cmp_data),
        .cmp_pc(cmp_pc), .cmp_tag(cmp_tag), .cmp_from_lsq(cmp_from_lsq),
        .conflict_cnt(conflict_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per-source queues plus the output slot.
    ld_result_t  q_lsq[$], q_mem[$];
    bit          m_valid, m_from_lsq, m_rr_lsq;
    logic [31:0] m_data, m_pc;
    logic [5:0]  m_tag;
    int unsigned m_cnt;
    bit          acc_lsq, acc_mem;   // handshake completed at the last edge

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit         lr, mr, ln, mn, pick;
        ld_result_t r;
        lr = q_lsq.size() < DEPTH;
        mr = q_mem.size() < DEPTH;
        acc_lsq = lsq_valid && lr;
        acc_mem = mem_valid && mr;
        if (rst) begin
            q_lsq.delete(); q_mem.delete();
            m_valid = 0; m_data = 0; m_pc = 0; m_tag = 0; m_from_lsq = 0;
            m_rr_lsq = 1; m_cnt = 0;
        end else begin
            ln = q_lsq.size() > 0;
            mn = q_mem.size() > 0;
            if (ln && mn && m_cnt < 16'hFFFF) m_cnt++;
            if (flush) begin
                q_lsq.delete(); q_mem.delete();
                m_valid = 0; m_rr_lsq = 1;
            end else begin
                if ((!m_valid || cmp_ready) && (ln || mn)) begin
                    pick = (ln && mn) ? m_rr_lsq : ln;
                    r = pick ? q_lsq.pop_front() : q_mem.pop_front();
                    m_valid = 1; m_data = r.data; m_pc = r.pc; m_tag = r.tag;
                    m_from_lsq = pick; m_rr_lsq = !pick;
                end else if (cmp_ready) begin
                    m_valid = 0;
                end
                if (acc_lsq) q_lsq.push_back('{data: lsq_data, pc: lsq_pc, tag: lsq_tag});
                if (acc_mem) q_mem.push_back('{data: mem_data, pc: mem_pc, tag: mem_tag});
            end
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".cmp_valid"}, cmp_valid, m_valid);
        chk({ph, ".lsq_ready"}, lsq_ready, q_lsq.size() < DEPTH);
        chk({ph, ".mem_ready"}, mem_ready, q_mem.size() < DEPTH);
        chk({ph, ".cmp_data"}, cmp_data, m_data);
        chk({ph, ".cmp_pc"}, cmp_pc, m_pc);
        chk({ph, ".cmp_tag"}, cmp_tag, m_tag);
        chk({ph, ".cmp_from_lsq"}, cmp_from_lsq, m_from_lsq);
        chk({ph, ".conflict_cnt"}, conflict_cnt, m_cnt);
    endtask

    task automatic tick(input string ph);
        model_step();
        @(posedge clk);
        #1;
        check_all(ph);
    endtask

    task automatic new_lsq();
        lsq_data = $urandom; lsq_pc = $urandom & 32'hFFFC; lsq_tag = 6'($urandom);
    endtask

    task automatic new_mem();
        mem_data = $urandom; mem_pc = $urandom & 32'hFFFC; mem_tag = 6'($urandom);
    endtask

    task automatic do_reset();
        rst = 1; flush = 0; lsq_valid = 0; mem_valid = 0; cmp_ready = 1;
        tick("reset");
        rst = 0;
    endtask

    initial begin
        int n_lsq_gnt, idx;
        rst = 1; flush = 0; lsq_valid = 0; mem_valid = 0; cmp_ready = 1;
        lsq_data = 0; lsq_pc = 0; lsq_tag = 0; mem_data = 0; mem_pc = 0; mem_tag = 0;

        // Reset values
        do_reset();
        chk("rst.cmp_valid", cmp_valid, 1'b0);
        chk("rst.lsq_ready", lsq_ready, 1'b1);
        chk("rst.mem_ready", mem_ready, 1'b1);

        // 1. Single source, two-cycle latency
        mem_valid = 1; mem_data = 32'hDEADBEEF; mem_pc = 32'h100; mem_tag = 6'd5;
        tick("t1.e0");
        mem_valid = 0;
        chk("t1.e0.no_bypass", cmp_valid, 1'b0);
        tick("t1.e1");
        chk("t1.valid", cmp_valid, 1'b1);
        chk("t1.data", cmp_data, 32'hDEADBEEF);
        chk("t1.pc", cmp_pc, 32'h100);
        chk("t1.tag", cmp_tag, 6'd5);
        chk("t1.from_lsq", cmp_from_lsq, 1'b0);
        tick("t1.drain");

        // 2. Same-edge collision after reset
        do_reset();
        lsq_valid = 1; lsq_data = 32'h11; lsq_pc = 32'h200; lsq_tag = 6'd1;
        mem_valid = 1; mem_data = 32'h22; mem_pc = 32'h204; mem_tag = 6'd2;
        tick("t2.push");
        lsq_valid = 0; mem_valid = 0;
        tick("t2.g0");
        chk("t2.first_data", cmp_data, 32'h11);
        chk("t2.first_src", cmp_from_lsq, 1'b1);
        tick("t2.g1");
        chk("t2.second_data", cmp_data, 32'h22);
        chk("t2.second_src", cmp_from_lsq, 1'b0);
        chk("t2.conflict", conflict_cnt, 16'd1);
        tick("t2.drain");

        // 3. Backpressure: producer holds each item until accepted
        do_reset();
        cmp_ready = 0; idx = 0;
        lsq_valid = 1; lsq_data = 32'hA0; lsq_pc = 32'h300; lsq_tag = 6'd10;
        for (int c = 0; c < 8; c++) begin
            tick("t3.stall");
            if (acc_lsq) begin
                idx++;
                if (idx < 4) begin
                    lsq_data = 32'hA0 + idx; lsq_pc = 32'h300 + 4*idx; lsq_tag = 6'(10 + idx);
                end else lsq_valid = 0;
            end
        end
        chk("t3.lsq_ready_low", lsq_ready, 1'b0);
        chk("t3.held_head", cmp_data, 32'hA0);
        cmp_ready = 1;
        for (int c = 0; c < 8; c++) begin
            tick("t3.drain");
            if (acc_lsq) lsq_valid = 0;
        end

        // 4. Fairness under continuous contention
        do_reset();
        n_lsq_gnt = 0;
        lsq_valid = 1; mem_valid = 1; new_lsq(); new_mem();
        for (int c = 0; c < 9; c++) begin
            tick("t4.fair");
            if (c > 0 && cmp_from_lsq) n_lsq_gnt++;
            if (acc_lsq) new_lsq();
            if (acc_mem) new_mem();
        end
        chk("t4.lsq_grants", n_lsq_gnt, 4);
        lsq_valid = 0; mem_valid = 0;
        for (int c = 0; c < 5; c++) tick("t4.drain");

        // 5. Flush with full FIFOs and a held output
        do_reset();
        cmp_ready = 0; lsq_valid = 1; mem_valid = 1; new_lsq(); new_mem();
        for (int c = 0; c < 4; c++) begin
            tick("t5.fill");
            if (acc_lsq) new_lsq();
            if (acc_mem) new_mem();
        end
        flush = 1;
        tick("t5.flush");
        chk("t5.cmp_valid", cmp_valid, 1'b0);
        chk("t5.lsq_ready", lsq_ready, 1'b1);
        chk("t5.mem_ready", mem_ready, 1'b1);
        flush = 0; lsq_valid = 0; mem_valid = 0; cmp_ready = 1;
        for (int c = 0; c < 4; c++) begin
            tick("t5.after");
            chk("t5.no_stale", cmp_valid, 1'b0);
        end

        // 6. Reset in a backpressured state
        cmp_ready = 0; lsq_valid = 1; mem_valid = 1; new_lsq(); new_mem();
        for (int c = 0; c < 4; c++) begin
            tick("t6.fill");
            if (acc_lsq) new_lsq();
            if (acc_mem) new_mem();
        end
        rst = 1;
        tick("t6.rst");
        chk("t6.cmp_valid", cmp_valid, 1'b0);
        chk("t6.cmp_data", cmp_data, 32'h0);
        chk("t6.conflict", conflict_cnt, 16'd0);
        rst = 0; lsq_valid = 0; mem_valid = 0; cmp_ready = 1;
        tick("t6.after");

        // Randomized traffic with occasional flush and reset
        for (int c = 0; c < 600; c++) begin
            if (!lsq_valid || acc_lsq) begin
                lsq_valid = ($urandom_range(0, 99) < 55); new_lsq();
            end
            if (!mem_valid || acc_mem) begin
                mem_valid = ($urandom_range(0, 99) < 55); new_mem();
            end
            cmp_ready = ($urandom_range(0, 99) < 65);
            flush     = ($urandom_range(0, 99) < 3);
            rst       = ($urandom_range(0, 299) == 0);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
